ed_point_add_mod: RTL

Parametrised twisted-Edwards (a = −1) extended-coordinate point adder, successor to the current fixed-width unreduced adder. It computes (X3:Y3:Z3:T3) = P1 + P2 fully reduced mod P, including the 2d and 2 factors. It accepts and returns operands through valid/ready handshakes. All field multiplications go through an external shared modular multiplier over a req/ack port, so one multiplier serves the adder, the doubler and the scalar-mult sequencer.

---
 rtl/ed_point_add_mod.sv | 209 ++++++++++++++++++++
 1 files changed

// File: rtl/ed_point_add_mod.sv
// Twisted-Edwards (a = -1) extended-coordinate point adder, fully reduced mod P; all
// field products go through a shared external multiplier. Define PADD_NEG_EN to enable P1 - P2.
module ed_point_add_mod #(
    parameter int unsigned  W   = 255,
    parameter logic [W-1:0] P   = 255'h7fffffff_ffffffff_ffffffff_ffffffff_ffffffff_ffffffff_ffffffff_ffffffed,
    // 2d mod P for edwards25519
    parameter logic [W-1:0] K2D = 255'h2406d9dc_56dffce7_198e80f2_eef3d130_00e0149a_8283b156_ebd69b94_26b2f159
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic         sub,
    input  logic [W-1:0] x1,
    input  logic [W-1:0] y1,
    input  logic [W-1:0] z1,
    input  logic [W-1:0] t1,
    input  logic [W-1:0] x2,
    input  logic [W-1:0] y2,
    input  logic [W-1:0] z2,
    input  logic [W-1:0] t2,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] x3,
    output logic [W-1:0] y3,
    output logic [W-1:0] z3,
    output logic [W-1:0] t3,
    output logic         mm_req,
    output logic [W-1:0] mm_a,
    output logic [W-1:0] mm_b,
    input  logic         mm_ack,
    input  logic [W-1:0] mm_p
);

    typedef enum logic [3:0] {
        S_IDLE, S_PRE,
        S_M0, S_M1, S_M2, S_M3, S_M4, S_M5, S_M6, S_M7, S_M8,
        S_MID1, S_MID2, S_DONE
    } state_e;

    function automatic logic [W-1:0] mod_add(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W:0] s;
        s = {1'b0, a} + {1'b0, b};
        if (s >= {1'b0, P}) s = s - {1'b0, P};
        return s[W-1:0];
    endfunction

    function automatic logic [W-1:0] mod_sub(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W:0] s;
        s = {1'b0, a} - {1'b0, b};
        if (s[W]) s = s + {1'b0, P};
        return s[W-1:0];
    endfunction

    state_e state_q, state_d;
    logic   gap_q, gap_d;
    logic   mm_req_q, mm_req_d;
    logic   in_ready_q, in_ready_d;
    logic   accept, is_mul, ack_fire;

    logic [W-1:0] x1_q, y1_q, z1_q, t1_q, x2_q, y2_q, z2_q, t2_q;
    logic [W-1:0] u1_q, u2_q, v1_q, v2_q;
    logic [W-1:0] a_q, b_q, c_q, cc_q, d_q, dd_q, e_q, f_q, g_q, h_q;
    logic [W-1:0] x2_in, t2_in;

`ifdef PADD_NEG_EN
    assign x2_in = sub ? mod_sub('0, x2) : x2;
    assign t2_in = sub ? mod_sub('0, t2) : t2;
`else
    logic unused_sub;
    assign unused_sub = sub;
    assign x2_in      = x2;
    assign t2_in      = t2;
`endif

    assign is_mul   = (state_q inside {[S_M0:S_M8]});
    assign ack_fire = is_mul && mm_req_q && mm_ack;
    assign accept   = (state_q == S_IDLE) && in_valid && in_ready_q;

    // Each M state spends one extra cycle after its ack so mm_req is low for a cycle.
    always_comb begin
        // NOTE: every variable written here gets a default first, otherwise a latch is inferred.
        state_d  = state_q;
        gap_d    = gap_q;
        mm_req_d = mm_req_q;
        unique case (state_q)
            S_IDLE: if (accept) state_d = S_PRE;
            S_PRE: begin
                state_d  = S_M0;
                mm_req_d = 1'b1;
            end
            S_MID1: state_d = S_MID2;
            S_MID2: begin
                state_d  = S_M5;
                mm_req_d = 1'b1;
            end
            S_DONE: if (out_ready) state_d = S_IDLE;
            default: begin
                if (gap_q) begin
                    gap_d = 1'b0;
                    unique case (state_q)
                        S_M0:    state_d = S_M1;
                        S_M1:    state_d = S_M2;
                        S_M2:    state_d = S_M3;
                        S_M3:    state_d = S_M4;
                        S_M4:    state_d = S_MID1;
                        S_M5:    state_d = S_M6;
                        S_M6:    state_d = S_M7;
                        S_M7:    state_d = S_M8;
                        default: state_d = S_DONE;
                    endcase
                    mm_req_d = (state_d != S_MID1) && (state_d != S_DONE);
                end else if (ack_fire) begin
                    gap_d    = 1'b1;
                    mm_req_d = 1'b0;
                end
            end
        endcase
        in_ready_d = (state_d == S_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: sequential state uses non-blocking assignments so all flops update together.
            state_q    <= S_IDLE;
            gap_q      <= 1'b0;
            mm_req_q   <= 1'b0;
            in_ready_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            gap_q      <= gap_d;
            mm_req_q   <= mm_req_d;
            in_ready_q <= in_ready_d;
        end
    end

    // NOTE: operand and intermediate registers are always written before use, so they carry no reset.
    always_ff @(posedge clk) begin
        if (accept) begin
            x1_q <= x1;    y1_q <= y1; z1_q <= z1; t1_q <= t1;
            x2_q <= x2_in; y2_q <= y2; z2_q <= z2; t2_q <= t2_in;
        end
        if (state_q == S_PRE) begin
            u1_q <= mod_sub(y1_q, x1_q);
            u2_q <= mod_sub(y2_q, x2_q);
            v1_q <= mod_add(y1_q, x1_q);
            v2_q <= mod_add(y2_q, x2_q);
        end
        if (ack_fire) begin
            unique case (state_q)
                S_M0:    a_q  <= mm_p;
                S_M1:    b_q  <= mm_p;
                S_M2:    c_q  <= mm_p;
                S_M3:    cc_q <= mm_p;
                S_M4:    d_q  <= mm_p;
                default: ;
            endcase
        end
        if (state_q == S_MID1) begin
            dd_q <= mod_add(d_q, d_q);
            e_q  <= mod_sub(b_q, a_q);
            h_q  <= mod_add(b_q, a_q);
        end
        if (state_q == S_MID2) begin
            f_q <= mod_sub(dd_q, cc_q);
            g_q <= mod_add(dd_q, cc_q);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x3 <= '0;
            y3 <= '0;
            z3 <= '0;
            t3 <= '0;
        end else if (ack_fire) begin
            unique case (state_q)
                S_M5:    x3 <= mm_p;
                S_M6:    y3 <= mm_p;
                S_M7:    t3 <= mm_p;
                S_M8:    z3 <= mm_p;
                default: ;
            endcase
        end
    end

    // Operands are a pure decode of state and registers; zero outside the M states.
    always_comb begin
        mm_a = '0;
        mm_b = '0;
        unique case (state_q)
            S_M0:    begin mm_a = u1_q; mm_b = u2_q; end
            S_M1:    begin mm_a = v1_q; mm_b = v2_q; end
            S_M2:    begin mm_a = t1_q; mm_b = t2_q; end
            S_M3:    begin mm_a = c_q;  mm_b = K2D;  end
            S_M4:    begin mm_a = z1_q; mm_b = z2_q; end
            S_M5:    begin mm_a = e_q;  mm_b = f_q;  end
            S_M6:    begin mm_a = g_q;  mm_b = h_q;  end
            S_M7:    begin mm_a = e_q;  mm_b = h_q;  end
            S_M8:    begin mm_a = f_q;  mm_b = g_q;  end
            default: ;
        endcase
    end

    assign in_ready  = in_ready_q;
    assign out_valid = (state_q == S_DONE);
    assign mm_req    = mm_req_q;

endmodule
